// File: rtl/sdram_arbiter_pkg.sv
// Shared types and memory-port widths for the SDRAM round-robin arbiter.
package sdram_arbiter_pkg;

    localparam int unsigned MEM_AW = 32;
    localparam int unsigned MEM_DW = 32;
    localparam int unsigned MEM_SW = 4;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } arb_state_e;

endpackage

// File: rtl/sdram_arb_rr.sv
// Combinational round-robin picker: one-hot grant of the first request at or after ptr.
module sdram_arb_rr #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);

    function automatic logic [PTR_W-1:0] wrap(input int unsigned v);
        return (v >= NREQ) ? PTR_W'(v - NREQ) : PTR_W'(v);
    endfunction

    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] pick;
    logic            found;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot   = '0;
        pick  = '0;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rot[PTR_W'(i)] = req[wrap(i + 32'(ptr))];
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (rot[PTR_W'(i)] && !found) begin
                pick[PTR_W'(i)] = 1'b1;
                found           = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            gnt[wrap(i + 32'(ptr))] = pick[PTR_W'(i)];
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing the sdramc valid/ready port among NREQ requesters, one transaction in flight.
// Optional performance counters are built when SDRAM_ARB_PERF_EN is defined.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned PERF_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          s_valid,
    output logic [NREQ-1:0]          s_ready,
    input  logic [NREQ*MEM_AW-1:0]   s_addr,
    input  logic [NREQ*MEM_DW-1:0]   s_wdata,
    input  logic [NREQ*MEM_SW-1:0]   s_wstrb,
    output logic [MEM_DW-1:0]        s_rdata,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [MEM_AW-1:0]        m_addr,
    output logic [MEM_DW-1:0]        m_wdata,
    output logic [MEM_SW-1:0]        m_wstrb,
    input  logic [MEM_DW-1:0]        m_rdata
`ifdef SDRAM_ARB_PERF_EN
    ,
    input  logic                     perf_clr,
    output logic [NREQ*PERF_W-1:0]   perf_grant,
    output logic [PERF_W-1:0]        perf_wait
`endif
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || PERF_W == 0) begin : g_bad_param
        $error("sdram_arbiter: NREQ must be 2..8 and PERF_W nonzero");
    end

    arb_state_e       state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d, pick;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, grant_idx;

    sdram_arb_rr #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (s_valid),
        .ptr (rr_ptr_q),
        .gnt (pick)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_q[i]) grant_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // grant_q is cleared on completion so the muxed outputs and s_ready stay quiet in IDLE.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|s_valid) begin
                    state_d = ST_BUSY;
                    grant_d = pick;
                end
            end
            ST_BUSY: begin
                if (m_ready) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_valid = (state_q == ST_BUSY);
        s_ready = (state_q == ST_BUSY) ? ({NREQ{m_ready}} & grant_q) : '0;
        s_rdata = m_rdata;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            m_addr  = m_addr  | (s_addr [MEM_AW*i +: MEM_AW] & {MEM_AW{grant_q[i]}});
            m_wdata = m_wdata | (s_wdata[MEM_DW*i +: MEM_DW] & {MEM_DW{grant_q[i]}});
            m_wstrb = m_wstrb | (s_wstrb[MEM_SW*i +: MEM_SW] & {MEM_SW{grant_q[i]}});
        end
    end

`ifdef SDRAM_ARB_PERF_EN
    logic [PERF_W-1:0] grant_cnt_q [NREQ];
    logic [PERF_W-1:0] wait_cnt_q;
    logic              waiting;

    assign waiting = |(s_valid & ~grant_q & ~s_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NREQ; k++) grant_cnt_q[k] <= '0;
            wait_cnt_q <= '0;
        end else if (perf_clr) begin
            for (int unsigned k = 0; k < NREQ; k++) grant_cnt_q[k] <= '0;
            wait_cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (s_ready[k] && !(&grant_cnt_q[k])) grant_cnt_q[k] <= grant_cnt_q[k] + 1'b1;
            end
            if (waiting && !(&wait_cnt_q)) wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        perf_grant = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            perf_grant[PERF_W*k +: PERF_W] = grant_cnt_q[k];
        end
    end

    assign perf_wait = wait_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_sdram_arbiter;

    localparam int NREQ = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      s_valid;
    logic [NREQ-1:0]      s_ready;
    logic [NREQ*32-1:0]   s_addr;
    logic [NREQ*32-1:0]   s_wdata;
    logic [NREQ*4-1:0]    s_wstrb;
    logic [31:0]          s_rdata;
    logic                 m_valid;
    logic                 m_ready;
    logic [31:0]          m_addr;
    logic [31:0]          m_wdata;
    logic [3:0]           m_wstrb;
    logic [31:0]          m_rdata;
`ifdef SDRAM_ARB_PERF_EN
    logic                 perf_clr;
    logic [NREQ*32-1:0]   perf_grant;
    logic [31:0]          perf_wait;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.NREQ(NREQ), .PERF_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata)
`ifdef SDRAM_ARB_PERF_EN
        ,
        .perf_clr   (perf_clr),
        .perf_grant (perf_grant),
        .perf_wait  (perf_wait)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        s_addr [32*k +: 32] = a;
        s_wdata[32*k +: 32] = wd;
        s_wstrb[4*k +: 4]   = ws;
    endtask

    // Transaction-level model: one outstanding grant, next search starts after the last served requester.
    bit busy;
    int gidx;
    int nptr;
    int others [NREQ];

    function automatic int pick_winner(input logic [NREQ-1:0] v, input int start);
        for (int n = 0; n < NREQ; n++) begin
            if (v[(start + n) % NREQ]) return (start + n) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_sr;
        if (!rst_n) begin
            busy = 1'b0;
            gidx = 0;
            nptr = 0;
            for (int k = 0; k < NREQ; k++) others[k] = 0;
        end
        exp_sr = (busy && m_ready) ? (NREQ'(1) << gidx) : '0;
        chk("m_valid", 32'(m_valid), 32'(busy));
        chk("s_ready", 32'(s_ready), 32'(exp_sr));
        chk("s_rdata", s_rdata, m_rdata);
        if (busy) begin
            chk("m_addr",  m_addr,  s_addr [32*gidx +: 32]);
            chk("m_wdata", m_wdata, s_wdata[32*gidx +: 32]);
            chk("m_wstrb", 32'(m_wstrb), 32'(s_wstrb[4*gidx +: 4]));
        end
        // Fairness is judged on the DUT's own completions, independent of the model's choice.
        for (int k = 0; k < NREQ; k++) begin
            if (s_ready[k]) begin
                checks++;
                if (others[k] > NREQ - 1) begin
                    errors++;
                    $display("FAIL fairness req%0d: got %0d other grants, expected <= %0d", k, others[k], NREQ - 1);
                end
                others[k] = 0;
            end else if (!s_valid[k]) begin
                others[k] = 0;
            end else if (s_ready != '0) begin
                others[k]++;
            end
        end
        if (rst_n) begin
            if (busy) begin
                if (m_ready) begin
                    busy = 1'b0;
                    nptr = (gidx + 1) % NREQ;
                end
            end else if (s_valid != '0) begin
                gidx = pick_winner(s_valid, nptr);
                busy = 1'b1;
            end
        end
    end

    initial begin
        int order[$];
        int cyc;
        logic [NREQ-1:0] sr_prev;

        rst_n = 1'b0; s_valid = '0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
        m_ready = 1'b0; m_rdata = '0;
`ifdef SDRAM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        repeat (3) step();
        at_neg();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_addr",  m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_wstrb", 32'(m_wstrb), 32'd0);

        // Single read
        step(); rst_n = 1'b1;
        set_req(0, 32'h100, 32'hDEADBEEF, 4'h0); s_valid = 3'b001;
        at_neg(); chk("t1_mvalid_t0", 32'(m_valid), 32'd0);
        step(); m_ready = 1'b1; m_rdata = 32'hCAFEF00D;
        at_neg();
        chk("t1_mvalid_t1", 32'(m_valid), 32'd1);
        chk("t1_maddr", m_addr, 32'h100);
        chk("t1_mwstrb", 32'(m_wstrb), 32'd0);
        chk("t1_sready", 32'(s_ready), 32'b001);
        chk("t1_srdata", s_rdata, 32'hCAFEF00D);
        step(); m_ready = 1'b0; s_valid = '0;
        at_neg(); chk("t1_mvalid_after", 32'(m_valid), 32'd0);

        // Write from req1 queued behind req0
        step(); set_req(0, 32'h200, 32'h0, 4'h0); s_valid = 3'b001;
        at_neg();
        step(); set_req(1, 32'h300, 32'h12345678, 4'hF); s_valid[1] = 1'b1;
        at_neg(); chk("t3_req0_granted", m_addr, 32'h200);
        step(); at_neg();
        step(); m_ready = 1'b1; m_rdata = 32'h0BADF00D;
        at_neg(); chk("t3_req0_sready", 32'(s_ready), 32'b001);
        step(); m_ready = 1'b0; s_valid[0] = 1'b0;
        at_neg(); chk("t3_gap_r1", 32'(m_valid), 32'd0);
        step(); at_neg();
        chk("t3_mvalid_r2", 32'(m_valid), 32'd1);
        chk("t3_mwdata", m_wdata, 32'h12345678);
        chk("t3_mwstrb", 32'(m_wstrb), 32'hF);
        chk("t3_maddr", m_addr, 32'h300);
        step(); m_ready = 1'b1;
        at_neg(); chk("t3_req1_sready", 32'(s_ready), 32'b010);
        step(); m_ready = 1'b0; s_valid = '0;
        at_neg();

        // Spurious m_ready while idle, then req1 drops its request while granted
        step(); m_ready = 1'b1;
        at_neg();
        chk("t5_idle_sready", 32'(s_ready), 32'd0);
        chk("t5_idle_mvalid", 32'(m_valid), 32'd0);
        step(); m_ready = 1'b0;
        at_neg(); chk("t5_idle_stays", 32'(m_valid), 32'd0);
        step(); set_req(1, 32'h400, 32'h0, 4'h0); s_valid = 3'b010;
        at_neg();
        step(); s_valid = '0;
        at_neg(); chk("t5_granted", 32'(m_valid), 32'd1);
        repeat (3) step();
        at_neg(); chk("t5_held", 32'(m_valid), 32'd1);
        step(); m_ready = 1'b1;
        at_neg(); chk("t5_sready_dropped", 32'(s_ready), 32'b010);
        step(); m_ready = 1'b0;
        at_neg(); chk("t5_done", 32'(m_valid), 32'd0);

        // Asynchronous reset mid-transaction
        step(); set_req(0, 32'h500, 32'h0, 4'h0); s_valid = 3'b001;
        at_neg();
        step(); at_neg(); chk("t4_busy", 32'(m_valid), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0; m_ready = 1'b1;
        #1;
        chk("t4_async_mvalid", 32'(m_valid), 32'd0);
        chk("t4_async_sready", 32'(s_ready), 32'd0);
        at_neg();
        step(); m_ready = 1'b0; s_valid = '0;
        at_neg();
        step(); rst_n = 1'b1; set_req(2, 32'h600, 32'hA5A5A5A5, 4'h3); s_valid = 3'b100;
        at_neg(); chk("t4_release_t0", 32'(m_valid), 32'd0);
        step(); at_neg();
        chk("t4_release_t1", 32'(m_valid), 32'd1);
        chk("t4_maddr", m_addr, 32'h600);
        step(); m_ready = 1'b1;
        at_neg(); chk("t4_sready", 32'(s_ready), 32'b100);
        step(); m_ready = 1'b0; s_valid = '0;
        at_neg();

        // All three requesting continuously from rr_ptr = 0
        step(); rst_n = 1'b0;
        at_neg();
        step(); rst_n = 1'b1;
        for (int k = 0; k < NREQ; k++) set_req(k, 32'h1000 * (k + 1), 32'h0, 4'h0);
        s_valid = 3'b111;
        cyc = 0;
        while (order.size() < 6 && cyc < 60) begin
            step();
            m_ready = m_valid;
            m_rdata = $urandom;
            at_neg();
            for (int k = 0; k < NREQ; k++) if (s_ready[k]) order.push_back(k);
            cyc++;
        end
        if (order.size() < 6) begin
            checks++; errors++;
            $display("FAIL t2_timeout: got %0d grants, expected 6 within 60 cycles", order.size());
        end else begin
            for (int i = 0; i < 6; i++) chk("t2_order", 32'(order[i]), 32'(i % 3));
        end
        step(); m_ready = 1'b0; s_valid = '0;
        at_neg();

`ifdef SDRAM_ARB_PERF_EN
        step(); perf_clr = 1'b1;
        at_neg();
        step(); perf_clr = 1'b0;
        at_neg(); chk("t6_clr_wait", perf_wait, 32'd0);
        for (int n = 0; n < 5; n++) begin
            step(); set_req(2, 32'h700 + 32'(n), 32'h0, 4'h0); s_valid = 3'b100;
            at_neg();
            step(); m_ready = 1'b1;
            at_neg();
            step(); m_ready = 1'b0; s_valid = '0;
            at_neg();
        end
        chk("t6_grant2", perf_grant[64 +: 32], 32'd5);
        chk("t6_grant0", perf_grant[0 +: 32], 32'd0);
        chk("t6_wait", perf_wait, 32'd5);
        step(); perf_clr = 1'b1;
        at_neg();
        step(); perf_clr = 1'b0;
        at_neg();
        chk("t6_clr_grant2", perf_grant[64 +: 32], 32'd0);
        chk("t6_clr_wait2", perf_wait, 32'd0);
`endif

        // Randomized traffic
        sr_prev = '0;
        repeat (3000) begin
            step();
            for (int k = 0; k < NREQ; k++) begin
                if (s_valid[k] && sr_prev[k]) begin
                    if ($urandom_range(1, 0) == 1)
                        set_req(k, $urandom, $urandom, ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom));
                    else
                        s_valid[k] = 1'b0;
                end else if (!s_valid[k] && $urandom_range(2, 0) == 0) begin
                    set_req(k, $urandom, $urandom, ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom));
                    s_valid[k] = 1'b1;
                end
            end
            if (m_valid) m_ready = ($urandom_range(2, 0) == 0);
            else         m_ready = ($urandom_range(7, 0) == 0);
            m_rdata = $urandom;
            at_neg();
            sr_prev = s_ready;
        end

        step(); s_valid = '0; m_ready = 1'b0;
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
